// File: rtl/mips_rf_pkg.sv
// rtl/mips_rf_pkg.sv - shared types and helpers for the MIPS register file
package mips_rf_pkg;

    typedef enum logic [0:0] {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

    localparam int ZERO_ADDR = 0;

    function automatic int rf_clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mips_rf_scoreboard.sv
// rtl/mips_rf_scoreboard.sv - per-register busy bits for multi-cycle producers
module mips_rf_scoreboard
    import mips_rf_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = rf_clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                set_en,
    input  logic [ADDR_W-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    output logic [NUM_REGS-1:0] busy
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            // A producer issued in the same cycle as a writeback keeps the register busy
            for (int i = 0; i < NUM_REGS; i++) begin
                if (set_en && (set_addr == ADDR_W'(i))) begin
                    busy[i] <= 1'b1;
                end else if (clr_en && (clr_addr == ADDR_W'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mips_regfile_sb.sv
// rtl/mips_regfile_sb.sv - register file with clear sequencer, write bypass and busy scoreboard
module mips_regfile_sb
    import mips_rf_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_RD   = 2,
    parameter int RA_INIT  = 255,
    parameter int ADDR_W   = rf_clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic                     ready
);

    localparam logic [0:0]        ST_INIT = 1'(RF_INIT);
    localparam logic [0:0]        ST_RUN  = 1'(RF_RUN);
    localparam logic [ADDR_W-1:0] ZERO    = ADDR_W'(ZERO_ADDR);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(NUM_REGS - 1);

    logic [0:0]          state;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [NUM_REGS-1:0] busy_vec;
    logic                run;
    logic                wr_ok;
    logic                claim_ok;
    logic                flush;

    assign run      = (state == ST_RUN);
    assign ready    = run;
    assign flush    = run && clear_req;
    assign wr_ok    = run && !clear_req && wr_en && (wr_addr != ZERO);
    assign claim_ok = run && !clear_req && claim_en && (claim_addr != ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else if (state == ST_INIT) begin
            ptr <= ptr + 1'b1;
            if (ptr == LAST) begin
                state <= ST_RUN;
            end
        end else if (clear_req) begin
            state <= ST_INIT;
            ptr   <= '0;
        end
    end

    // Storage has no reset; the sequencer is the only thing that initialises it
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[ptr] <= (ptr == LAST) ? DATA_W'(RA_INIT) : '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    mips_rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .set_en   (claim_ok),
        .set_addr (claim_addr),
        .clr_en   (wr_ok),
        .clr_addr (wr_addr),
        .busy     (busy_vec)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rd_data[i*DATA_W +: DATA_W] = '0;
            rd_busy[i]                  = 1'b0;
            if (run && (ra != ZERO)) begin
                if (wr_en && (wr_addr == ra)) begin
                    rd_data[i*DATA_W +: DATA_W] = wr_data;
                end else begin
                    rd_data[i*DATA_W +: DATA_W] = mem[ra];
                    rd_busy[i]                  = busy_vec[ra];
                end
            end
        end
    end

endmodule
